gray_ptr_sync: RTL and testbench
================================

GRAY_PTR_SYNC -- requirements
Module: gray_ptr_sync

Interface
REQ-001 The block SHALL have parameter ADDRSIZE, default 4, giving pointer width ADDRSIZE+1 (P) including the wrap bit.
REQ-002 The block SHALL have parameter STAGES, default 2, giving the synchronizer depth; legal range 2..4.
REQ-003 Port: rclk, input, 1, destination-domain clock; all state on its rising edge.
REQ-004 Port: rrst_n, input, 1, reset; one clock; reset is synchronous and active-low.
REQ-005 Port: wptr, input, P, Gray-coded pointer from a foreign clock domain; treated as asynchronous.
REQ-006 Port: err_clr, input, 1, synchronous clear of gray_err.
REQ-007 Port: rq_wptr, output, P, synchronized Gray pointer.
REQ-008 Port: rq_wptr_bin, output, P, binary decode of the synchronized pointer.
REQ-009 Port: ptr_adv, output, 1, one-cycle pulse when the decoded pointer moved.
REQ-010 Port: adv_delta, output, P, distance moved, in binary, modulo 2^P.
REQ-011 Port: ptr_valid, output, 1, high once the synchronizer chain holds post-reset data.
REQ-012 Port: gray_err, output, 1, sticky flag for a multi-bit Gray step.

Function
REQ-013 Each rclk edge SHALL execute: stage1 <= wptr; stage k <= stage k-1 for k = 2..STAGES; rq_wptr = stage STAGES (latency STAGES edges).
REQ-014 No logic SHALL sit between wptr and stage1; stage1 feeds only stage2.
REQ-015 Each edge SHALL register rq_wptr_bin <= gray2bin(rq_wptr), with bin[P-1] = g[P-1] and bin[i] = bin[i+1] XOR g[i]; total wptr-to-rq_wptr_bin latency STAGES+1.
REQ-016 On the same edge, adv_delta SHALL be registered as (gray2bin(rq_wptr) - rq_wptr_bin) mod 2^P, using unsigned P-bit wrap arithmetic.
REQ-017 On the same edge, ptr_adv SHALL be registered as (new delta != 0) AND ptr_valid; otherwise both outputs follow their formulas every cycle.
REQ-018 Wrap-around SHALL be correct: a step from binary 2^P-1 to 0 gives adv_delta = 1.
REQ-019 A settle counter SHALL count edges after reset release and saturate; ptr_valid SHALL rise on the edge where STAGES+1 post-reset edges have completed, and then stay high.
REQ-020 While ptr_valid = 0, ptr_adv SHALL be 0 and gray_err SHALL NOT set; adv_delta is don't-care.
REQ-021 A registered copy rq_wptr_d SHALL hold the previous rq_wptr.
REQ-022 gray_err SHALL set when ptr_valid = 1 and popcount(rq_wptr XOR rq_wptr_d) > 1.
REQ-023 gray_err SHALL remain set until err_clr = 1 is sampled.
REQ-024 If set and clear occur in the same cycle, set SHALL win.
REQ-025 A one-bit Gray change, or no change, SHALL never set gray_err.
REQ-026 A pointer held constant SHALL produce ptr_adv = 0 and adv_delta = 0 from the second cycle after it reaches rq_wptr.

Reset
REQ-027 When rrst_n = 0 is sampled, every edge SHALL clear all stages, rq_wptr_d, rq_wptr_bin, adv_delta, ptr_adv, gray_err, ptr_valid and the settle counter to 0.
REQ-028 Reset asserted mid-operation SHALL take effect at the next edge, regardless of pending stage contents or err_clr.
REQ-029 After reset release, the REQ-019 sequence SHALL restart from count 0.
REQ-030 Outputs SHALL be 0 from the first reset edge until their normal update.

Verification
REQ-031 Latency: STAGES=2, ADDRSIZE=4; reset, then hold wptr=0 for 4 edges; drive wptr=5'b00001 -> rq_wptr=00001 after 2 edges; rq_wptr_bin=1, adv_delta=1 and ptr_adv=1 one edge later; ptr_adv=0 the next edge.
REQ-032 Wrap: walk the Gray sequence 31 -> 0, i.e. Gray 10000 -> 00000 -> rq_wptr_bin 31 then 0; adv_delta=1; gray_err stays 0.
REQ-033 Burst: wptr jumps from Gray of 3 to Gray of 7 in one cycle (00010 -> 00100, 2 bits) -> gray_err=1 and adv_delta=4; gray_err persists 10 cycles; err_clr pulse clears it next edge.
REQ-034 Set-vs-clear: a 2-bit Gray step with err_clr=1 in the same cycle -> gray_err=1.
REQ-035 Settle: STAGES=3, wptr=00110 held through reset release -> ptr_valid rises after exactly 4 edges; ptr_adv stays 0 throughout, although rq_wptr_bin changes 0 -> 4.
REQ-036 Mid-op reset: rrst_n=0 for one edge while gray_err=1 and ptr_valid=1 -> all outputs 0 the next edge; ptr_valid rises again STAGES+1 edges after release.

Source files
------------

// File: rtl/gray_ptr_sync.sv
// Brings a Gray-coded pointer from a foreign clock domain into rclk through a flop chain.
// Also decodes it to binary, reports how far it moved, and flags illegal multi-bit Gray steps.
module gray_ptr_sync #(
  parameter int ADDRSIZE = 4,
  parameter int STAGES   = 2
) (
  input  logic              rclk,
  input  logic              rrst_n,
  input  logic [ADDRSIZE:0] wptr,
  input  logic              err_clr,
  output logic [ADDRSIZE:0] rq_wptr,
  output logic [ADDRSIZE:0] rq_wptr_bin,
  output logic              ptr_adv,
  output logic [ADDRSIZE:0] adv_delta,
  output logic              ptr_valid,
  output logic              gray_err
);

  localparam int P = ADDRSIZE + 1;
  localparam logic [2:0] SETTLE_MAX = 3'(STAGES + 1);

  logic [P-1:0] sync_q [STAGES];
  logic [P-1:0] rq_wptr_d;
  logic [2:0]   settle_cnt;

  logic [P-1:0] new_bin;
  logic [P-1:0] new_delta;
  logic [P-1:0] gray_diff;
  logic         multi_bit;

  function automatic logic [P-1:0] gray2bin(input logic [P-1:0] g);
    logic [P-1:0] b;
    b[P-1] = g[P-1];
    for (int i = P - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign rq_wptr = sync_q[STAGES-1];

  // More than one bit set means the pointer skipped Gray codes between samples.
  always_comb begin
    new_bin   = gray2bin(rq_wptr);
    new_delta = new_bin - rq_wptr_bin;
    gray_diff = rq_wptr ^ rq_wptr_d;
    multi_bit = (gray_diff & (gray_diff - P'(1))) != '0;
  end

  // wptr lands directly in the first flop; nothing else may sample it.
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= wptr;
      for (int k = 1; k < STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      rq_wptr_d   <= '0;
      rq_wptr_bin <= '0;
      adv_delta   <= '0;
      ptr_adv     <= 1'b0;
      gray_err    <= 1'b0;
      ptr_valid   <= 1'b0;
      settle_cnt  <= '0;
    end else begin
      rq_wptr_d   <= rq_wptr;
      rq_wptr_bin <= new_bin;
      adv_delta   <= new_delta;
      ptr_adv     <= (new_delta != '0) && ptr_valid;
      // A same-cycle set overrides the clear so no error is lost.
      gray_err    <= (ptr_valid && multi_bit) || (gray_err && !err_clr);
      if (settle_cnt != SETTLE_MAX) begin
        settle_cnt <= settle_cnt + 3'd1;
      end
      if (settle_cnt >= SETTLE_MAX - 3'd1) begin
        ptr_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Directed self-checking bench for gray_ptr_sync: a STAGES=2 instance for latency, wrap,
// burst, error and mid-operation reset, and a STAGES=3 instance for the settle sequence.
module tb_gray_ptr_sync;

  logic       rclk;
  logic       rrst_n,  err_clr;
  logic [4:0] wptr;
  logic [4:0] rq_wptr, rq_wptr_bin, adv_delta;
  logic       ptr_adv, ptr_valid, gray_err;

  logic       rrst_n3, err_clr3;
  logic [4:0] wptr3;
  logic [4:0] rq_wptr3, rq_wptr_bin3, adv_delta3;
  logic       ptr_adv3, ptr_valid3, gray_err3;

  int checks = 0;
  int fails  = 0;

  gray_ptr_sync #(.ADDRSIZE(4), .STAGES(2)) dut2 (
    .rclk(rclk), .rrst_n(rrst_n), .wptr(wptr), .err_clr(err_clr),
    .rq_wptr(rq_wptr), .rq_wptr_bin(rq_wptr_bin), .ptr_adv(ptr_adv),
    .adv_delta(adv_delta), .ptr_valid(ptr_valid), .gray_err(gray_err)
  );

  gray_ptr_sync #(.ADDRSIZE(4), .STAGES(3)) dut3 (
    .rclk(rclk), .rrst_n(rrst_n3), .wptr(wptr3), .err_clr(err_clr3),
    .rq_wptr(rq_wptr3), .rq_wptr_bin(rq_wptr_bin3), .ptr_adv(ptr_adv3),
    .adv_delta(adv_delta3), .ptr_valid(ptr_valid3), .gray_err(gray_err3)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  function automatic logic [4:0] bin2gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Advance n rising edges; inputs are driven and outputs sampled 1ns after each edge.
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge rclk);
      #1;
    end
  endtask

  initial begin
    rrst_n = 1'b0; err_clr = 1'b0; wptr = 5'b00000;
    rrst_n3 = 1'b0; err_clr3 = 1'b0; wptr3 = 5'b00000;

    applyStimulus(2);
    checkOutput("rst_rq_wptr",  rq_wptr,     0);
    checkOutput("rst_bin",      rq_wptr_bin, 0);
    checkOutput("rst_delta",    adv_delta,   0);
    checkOutput("rst_adv",      ptr_adv,     0);
    checkOutput("rst_valid",    ptr_valid,   0);
    checkOutput("rst_err",      gray_err,    0);

    // Settle and latency
    rrst_n = 1'b1;
    applyStimulus(2);
    checkOutput("settle_valid_e2", ptr_valid, 0);
    applyStimulus(1);
    checkOutput("settle_valid_e3", ptr_valid, 1);
    checkOutput("settle_adv_e3",   ptr_adv,   0);
    applyStimulus(1);
    wptr = 5'b00001;
    applyStimulus(1);
    checkOutput("lat_rq_e1", rq_wptr, 0);
    applyStimulus(1);
    checkOutput("lat_rq_e2",  rq_wptr,     1);
    checkOutput("lat_bin_e2", rq_wptr_bin, 0);
    checkOutput("lat_adv_e2", ptr_adv,     0);
    applyStimulus(1);
    checkOutput("lat_bin_e3",   rq_wptr_bin, 1);
    checkOutput("lat_delta_e3", adv_delta,   1);
    checkOutput("lat_adv_e3",   ptr_adv,     1);
    applyStimulus(1);
    checkOutput("lat_adv_e4",   ptr_adv,   0);
    checkOutput("lat_delta_e4", adv_delta, 0);

    // Wrap: walk up to 31 then step to 0
    for (int b = 2; b < 32; b++) begin
      wptr = bin2gray(5'(b));
      applyStimulus(1);
    end
    applyStimulus(3);
    checkOutput("walk_rq_31",  rq_wptr,     5'b10000);
    checkOutput("walk_bin_31", rq_wptr_bin, 31);
    checkOutput("walk_err",    gray_err,    0);
    wptr = 5'b00000;
    applyStimulus(3);
    checkOutput("wrap_bin",   rq_wptr_bin, 0);
    checkOutput("wrap_delta", adv_delta,   1);
    checkOutput("wrap_adv",   ptr_adv,     1);
    checkOutput("wrap_err",   gray_err,    0);
    applyStimulus(1);
    checkOutput("hold_delta", adv_delta, 0);
    checkOutput("hold_adv",   ptr_adv,   0);

    // Burst: Gray 3 (00010) -> Gray 7 (00100)
    wptr = 5'b00001; applyStimulus(1);
    wptr = 5'b00011; applyStimulus(1);
    wptr = 5'b00010; applyStimulus(3);
    checkOutput("pre_burst_bin", rq_wptr_bin, 3);
    checkOutput("pre_burst_err", gray_err,    0);
    wptr = 5'b00100;
    applyStimulus(3);
    checkOutput("burst_bin",   rq_wptr_bin, 7);
    checkOutput("burst_delta", adv_delta,   4);
    checkOutput("burst_adv",   ptr_adv,     1);
    checkOutput("burst_err",   gray_err,    1);
    applyStimulus(10);
    checkOutput("err_sticky", gray_err, 1);
    err_clr = 1'b1;
    applyStimulus(1);
    err_clr = 1'b0;
    checkOutput("err_cleared", gray_err, 0);

    // Set beats clear: 00100 -> 00111 (binary 7 -> 5)
    wptr = 5'b00111;
    applyStimulus(2);
    err_clr = 1'b1;
    applyStimulus(1);
    err_clr = 1'b0;
    checkOutput("setclr_err",   gray_err,    1);
    checkOutput("setclr_bin",   rq_wptr_bin, 5);
    checkOutput("setclr_delta", adv_delta,   30);

    // Mid-operation reset
    checkOutput("pre_rst_valid", ptr_valid, 1);
    rrst_n = 1'b0;
    applyStimulus(1);
    rrst_n = 1'b1;
    checkOutput("midrst_rq",    rq_wptr,     0);
    checkOutput("midrst_bin",   rq_wptr_bin, 0);
    checkOutput("midrst_delta", adv_delta,   0);
    checkOutput("midrst_adv",   ptr_adv,     0);
    checkOutput("midrst_valid", ptr_valid,   0);
    checkOutput("midrst_err",   gray_err,    0);
    applyStimulus(2);
    checkOutput("resettle_valid_e2", ptr_valid, 0);
    checkOutput("resettle_rq_e2",    rq_wptr,   5'b00111);
    applyStimulus(1);
    checkOutput("resettle_valid_e3", ptr_valid,   1);
    checkOutput("resettle_bin_e3",   rq_wptr_bin, 5);
    checkOutput("resettle_adv_e3",   ptr_adv,     0);
    applyStimulus(1);
    checkOutput("resettle_err_e4", gray_err, 0);

    // STAGES=3 settle with wptr held through reset release
    wptr3 = 5'b00110;
    applyStimulus(2);
    checkOutput("s3_rst_valid", ptr_valid3,   0);
    checkOutput("s3_rst_bin",   rq_wptr_bin3, 0);
    rrst_n3 = 1'b1;
    applyStimulus(2);
    checkOutput("s3_rq_e2", rq_wptr3, 0);
    applyStimulus(1);
    checkOutput("s3_valid_e3", ptr_valid3,   0);
    checkOutput("s3_rq_e3",    rq_wptr3,     5'b00110);
    checkOutput("s3_bin_e3",   rq_wptr_bin3, 0);
    checkOutput("s3_adv_e3",   ptr_adv3,     0);
    applyStimulus(1);
    checkOutput("s3_valid_e4", ptr_valid3,   1);
    checkOutput("s3_bin_e4",   rq_wptr_bin3, 4);
    checkOutput("s3_adv_e4",   ptr_adv3,     0);
    checkOutput("s3_err_e4",   gray_err3,    0);
    applyStimulus(1);
    checkOutput("s3_adv_e5",   ptr_adv3,   0);
    checkOutput("s3_delta_e5", adv_delta3, 0);
    checkOutput("s3_valid_e5", ptr_valid3, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
